// File: rtl/demux_deser16_pkg.sv
// Shared constants and types for the 1-to-16 serial demux/deserializer.
//   WIDTH   : number of output bit lanes (fixed at 16)
//   SEL_W   : lane index width (log2 WIDTH)
//   state_t : frame collection FSM states
package demux_deser16_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/demux_dec4to16.sv
// 4-to-16 one-hot lane decoder; the enable gates every lane so a bit that
// is not accepted cannot touch the shadow word or the lane mask.
//   sel      : lane index
//   en       : decode enable (bit accepted this cycle)
//   onehot_c : one-hot lane strobe, all zero when en is low
module demux_dec4to16
    import demux_deser16_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] onehot_c
);

    // Single-lane strobe
    always_comb begin
        onehot_c = '0;
        if (en) begin
            onehot_c[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_deser16.sv
// Serial-to-parallel demultiplexer: collects 16 serial bits into a word,
// either in auto-increment lane order or at addressed lanes, and presents
// the completed word with a valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   din        : serial data bit, qualified by din_valid
//   start      : frame start; restarts collection from lane 0
//   sel_mode   : 0 auto-increment lanes, 1 addressed lanes (latched at start)
//   sel_in     : target lane in addressed mode
//   dout       : last completed word, lane i at dout[i]
//   dout_valid : dout holds an unacknowledged word
//   dout_ready : consumer accepts dout when high together with dout_valid
//   busy       : frame collection in progress
//   cur_sel    : next lane to be written in auto mode (0 in addressed mode)
//   overrun    : sticky, a completed word replaced an unacknowledged one
// Only WIDTH = 16 / SEL_W = 4 is supported (fixed-size lane decoder).
module demux_deser16 #(
    parameter int unsigned WIDTH = demux_deser16_pkg::WIDTH,
    parameter int unsigned SEL_W = demux_deser16_pkg::SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             start,
    input  logic             sel_mode,
    input  logic [SEL_W-1:0] sel_in,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [SEL_W-1:0] cur_sel,
    output logic             overrun
);

    import demux_deser16_pkg::state_t;
    import demux_deser16_pkg::IDLE;
    import demux_deser16_pkg::COLLECT;

    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(WIDTH - 1);

    // Registered state
    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] mask;
    logic             mode;

    // Next-state values
    state_t           state_next;
    logic [SEL_W-1:0] cur_sel_next;
    logic [WIDTH-1:0] shadow_next;
    logic [WIDTH-1:0] mask_next;
    logic             mode_next;
    logic [WIDTH-1:0] dout_next;
    logic             dout_valid_next;
    logic             busy_next;
    logic             overrun_next;

    // Front-end lane selection
    logic             frame_mode_c;
    logic             accept_c;
    logic [SEL_W-1:0] base_idx_c;
    logic [WIDTH-1:0] base_shadow_c;
    logic [WIDTH-1:0] base_mask_c;
    logic [SEL_W-1:0] lane_c;
    logic [WIDTH-1:0] lane_hot_c;
    logic             complete_c;

    // A start restarts the frame in the same cycle, so the bit that arrives
    // with it is written on top of a cleared word/mask at index 0.
    always_comb begin
        frame_mode_c  = start ? sel_mode : mode;
        accept_c      = din_valid && (start || (state == COLLECT));
        base_idx_c    = start ? '0 : cur_sel;
        base_shadow_c = start ? '0 : shadow;
        base_mask_c   = start ? '0 : mask;
        lane_c        = frame_mode_c ? sel_in : base_idx_c;
    end

    demux_dec4to16 u_dec (
        .sel      (lane_c),
        .en       (accept_c),
        .onehot_c (lane_hot_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_sel    <= '0;
            shadow     <= '0;
            mask       <= '0;
            mode       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            cur_sel    <= cur_sel_next;
            shadow     <= shadow_next;
            mask       <= mask_next;
            mode       <= mode_next;
            dout       <= dout_next;
            dout_valid <= dout_valid_next;
            busy       <= busy_next;
            overrun    <= overrun_next;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_next      = state;
        cur_sel_next    = base_idx_c;
        shadow_next     = base_shadow_c;
        mask_next       = base_mask_c;
        mode_next       = mode;
        dout_next       = dout;
        dout_valid_next = dout_valid;
        overrun_next    = overrun;
        complete_c      = 1'b0;

        if (dout_valid && dout_ready) begin
            dout_valid_next = 1'b0;
        end

        if (start) begin
            state_next = COLLECT;
            mode_next  = sel_mode;
        end

        if (accept_c) begin
            shadow_next = (base_shadow_c & ~lane_hot_c) | (lane_hot_c & {WIDTH{din}});
            mask_next   = base_mask_c | lane_hot_c;
            if (frame_mode_c) begin
                // Addressed: done once every lane has been written at least once
                cur_sel_next = '0;
                complete_c   = &mask_next;
            end else begin
                // Auto: done on the last lane; index wraps back to 0
                cur_sel_next = base_idx_c + SEL_W'(1);
                complete_c   = (base_idx_c == LAST_LANE);
            end
        end

        if (complete_c) begin
            state_next      = IDLE;
            mask_next       = '0;
            dout_next       = shadow_next;
            dout_valid_next = 1'b1;
            // A simultaneous acknowledge consumes the old word, so no loss
            if (dout_valid && !dout_ready) begin
                overrun_next = 1'b1;
            end
        end

        busy_next = (state_next == COLLECT);
    end

endmodule

// File: doc/demux_deser16.md
DEMUX_DESER16 -- requirements
Module: demux_deser16

Interface
REQ-001 Parameter WIDTH, default 16, number of output bit lanes; only 16 is supported.
REQ-002 Parameter SEL_W, default 4, lane index width (log2 WIDTH).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  1  serial data bit.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 start  input  1  frame start pulse; lane index returns to 0.
REQ-008 sel_mode  input  1  0 = auto-increment lane, 1 = addressed lane via sel_in.
REQ-009 sel_in  input  SEL_W  target lane in addressed mode.
REQ-010 dout  output  WIDTH  last completed word; lane i at dout[i].
REQ-011 dout_valid  output  1  dout holds an unacknowledged word.
REQ-012 dout_ready  input  1  consumer accepts dout when high with dout_valid.
REQ-013 busy  output  1  frame collection in progress.
REQ-014 cur_sel  output  SEL_W  next lane to be written in auto mode.
REQ-015 overrun  output  1  sticky: a completed word overwrote an unacknowledged word.

Function
REQ-016 FSM states are IDLE and COLLECT; busy SHALL equal (state == COLLECT).
REQ-017 In IDLE, din_valid without start SHALL be ignored.
REQ-018 start in any state SHALL enter COLLECT, clear shadow word and lane mask, set index 0, and latch sel_mode for the whole frame.
REQ-019 If din_valid is high together with start, that bit SHALL be captured as the first bit of the new frame (lane 0 auto, sel_in addressed).
REQ-020 start in COLLECT SHALL discard the partial frame without any dout update.
REQ-021 Auto mode: each accepted bit SHALL write shadow[index], and index SHALL increment by 1; the first bit lands in lane 0.
REQ-022 Auto mode: the frame SHALL complete on the cycle the bit at index 15 is accepted; index SHALL wrap to 0.
REQ-023 Addressed mode: each accepted bit SHALL write shadow[sel_in] and set mask[sel_in]; repeated writes overwrite the bit and leave the mask unchanged.
REQ-024 Addressed mode: the frame SHALL complete on the cycle the mask becomes all ones.
REQ-025 On completion, dout SHALL be loaded with the full word including the final bit, and dout_valid SHALL be 1 in the next cycle (latency 1); the FSM SHALL return to IDLE.
REQ-026 dout_valid SHALL stay high and dout stable until a cycle with dout_valid && dout_ready; it SHALL then clear on the following cycle.
REQ-027 If completion and acknowledge coincide, the new word SHALL load, dout_valid SHALL remain 1, and overrun SHALL NOT set.
REQ-028 If completion occurs while dout_valid = 1 without acknowledge, the new word SHALL overwrite dout and overrun SHALL set and stay set until rst.
REQ-029 cur_sel SHALL reflect the registered auto index; in addressed mode it SHALL hold 0.

Reset
REQ-030 rst SHALL force, on the next edge: state IDLE, index 0, shadow 0, mask 0, dout 0, dout_valid 0, busy 0, overrun 0.
REQ-031 rst SHALL take priority over start, din_valid and dout_ready in the same cycle; a partial frame SHALL be lost.

Structure
REQ-032 Package demux_deser16_pkg SHALL hold WIDTH and SEL_W constants and the state enum type (IDLE, COLLECT).
REQ-033 Sub-module demux_dec4to16 SHALL implement the 4-to-16 one-hot lane decoder that gates the shadow and mask writes.

Verification
REQ-034 Auto mode: start + 16 valid bits of 16'h5555, LSB first -> dout = 16'h5555, dout_valid = 1 one cycle after the 16th bit, busy = 0.
REQ-035 Addressed mode: bits written to lanes 15..0 in reverse order with data 16'hA5C3 -> dout = 16'hA5C3 only after lane 0 is written; a duplicate write to lane 7 leaves the mask unchanged.
REQ-036 Restart: 8 bits of 1 sent, then start with din_valid = 1 and din = 0, then 15 bits of 0 -> dout = 16'h0000, no intermediate dout_valid.
REQ-037 Handshake: dout_ready held 0 and two frames completed (16'h00FF, then 16'hFF00) -> dout = 16'hFF00, overrun = 1; an ack coinciding with completion -> overrun stays 0.
REQ-038 Reset mid-frame: rst after 5 auto bits -> next cycle all outputs 0, cur_sel = 0; a fresh 16-bit frame then completes correctly.
